des_job_dispatcher: RTL

DES_JOB_DISPATCHER -- requirements
Module: des_job_dispatcher

---
 rtl/des_dispatch_pkg.sv | 17 +
 rtl/des_engine_tracker.sv | 46 ++++
 rtl/des_job_dispatcher.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/des_dispatch_pkg.sv
// des_dispatch_pkg
//   Shared types and default widths for the DES job dispatcher slice.
//   engine_state_t : per-engine tracker state (IDLE, PENDING, BUSY)
//   DES_BLOCK_WIDTH: default plaintext width (64)
//   DES_KEY_WIDTH  : default key width (64)
package des_dispatch_pkg;

   localparam int DES_BLOCK_WIDTH = 64;
   localparam int DES_KEY_WIDTH   = 64;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PENDING = 2'd1,
      BUSY    = 2'd2
   } engine_state_t;

endpackage

// File: rtl/des_engine_tracker.sv
// des_engine_tracker
//   Follows one DES engine through launch and completion so the dispatcher
//   never launches twice onto an engine that has not yet picked up a job.
//   Ports:
//     clk    : clock, rising edge
//     rst_n  : asynchronous active-low reset (state -> IDLE)
//     launch : dispatcher issued a start strobe to this engine this cycle
//     active : busy indication from the engine
//     state  : registered tracker state (engine_state_t encoding)
//     idle   : tracker is in IDLE
module des_engine_tracker
   import des_dispatch_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       launch,
   input  logic       active,
   output logic [1:0] state,
   output logic       idle
);

   engine_state_t state_q;
   engine_state_t state_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         // An engine that turns busy on its own is tracked as BUSY so it is
         // not launched onto until it drops active again.
         IDLE:    if (launch) state_d = PENDING;
                  else if (active) state_d = BUSY;
         PENDING: if (active) state_d = BUSY;
         BUSY:    if (!active) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign state = state_q;
   assign idle  = (state_q == IDLE);

endmodule

// File: rtl/des_job_dispatcher.sv
// des_job_dispatcher
//   Queues {plaintext,key} jobs in a DEPTH-entry FIFO and launches them
//   one per cycle onto NUM_ENGINES DES engines with round-robin selection.
//   Optional feature macro: DES_DISPATCH_STATS_EN adds job statistics ports.
//   Ports:
//     clk, rst_n            : clock (rising edge), async active-low reset
//     push_strobe_din       : enqueue plaintext_din/key_din this cycle
//     plaintext_din, key_din: job contents
//     active_des_engine_din : per-engine busy indication
//     full_dout             : FIFO holds DEPTH jobs
//     overflow_dout         : sticky, a push was dropped while full
//     start_strobe_dout     : one-hot, one-cycle launch strobe
//     plaintext_dout/key_dout: launched job (zero when no launch)
//     jobs_issued_dout      : (stats) launches, wraps at 2^32
//     jobs_dropped_dout     : (stats) dropped pushes, saturates at 0xFFFF
module des_job_dispatcher
   import des_dispatch_pkg::*;
#(
   parameter int DATA_WIDTH  = DES_BLOCK_WIDTH,
   parameter int KEY_WIDTH   = DES_KEY_WIDTH,
   parameter int DEPTH       = 4,
   parameter int NUM_ENGINES = 2
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   push_strobe_din,
   input  logic [0:DATA_WIDTH-1]  plaintext_din,
   input  logic [0:KEY_WIDTH-1]   key_din,
   input  logic [NUM_ENGINES-1:0] active_des_engine_din,
   output logic                   full_dout,
   output logic                   overflow_dout,
   output logic [NUM_ENGINES-1:0] start_strobe_dout,
   output logic [0:DATA_WIDTH-1]  plaintext_dout,
   output logic [0:KEY_WIDTH-1]   key_dout
`ifdef DES_DISPATCH_STATS_EN
   ,
   output logic [31:0]            jobs_issued_dout,
   output logic [15:0]            jobs_dropped_dout
`endif
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int RR_W  = (NUM_ENGINES > 1) ? $clog2(NUM_ENGINES) : 1;

   logic [0:DATA_WIDTH-1]  pt_mem  [DEPTH];
   logic [0:KEY_WIDTH-1]   key_mem [DEPTH];
   logic [PTR_W-1:0]       wr_ptr;
   logic [PTR_W-1:0]       rd_ptr;
   logic [PTR_W:0]         count;
   logic [RR_W-1:0]        rr_ptr;

   logic                   push_ok;
   logic                   drop;
   logic                   launch;
   logic [RR_W-1:0]        grant_idx;
   logic [NUM_ENGINES-1:0] launch_vec;
   logic [NUM_ENGINES-1:0] eng_idle;
   logic [NUM_ENGINES-1:0] eligible;
   // Tracker states are kept at this level for debug probing only.
   logic [1:0]             trk_state_unused [NUM_ENGINES];

   // Full comes straight from the registered count, so a pop in the same
   // cycle never makes room for a push that arrives while full.
   assign full_dout = (count == (PTR_W+1)'(DEPTH));
   assign push_ok   = push_strobe_din & ~full_dout;
   assign drop      = push_strobe_din & full_dout;

   for (genvar g = 0; g < NUM_ENGINES; g++) begin : g_trk
      des_engine_tracker u_trk (
         .clk    (clk),
         .rst_n  (rst_n),
         .launch (launch_vec[g]),
         .active (active_des_engine_din[g]),
         .state  (trk_state_unused[g]),
         .idle   (eng_idle[g])
      );
      assign eligible[g] = (count != '0) & eng_idle[g] & ~active_des_engine_din[g];
   end

   // Round-robin search starting at rr_ptr; first eligible engine wins.
   always_comb begin
      logic [RR_W:0]   sum;
      logic [RR_W-1:0] cand;
      launch     = 1'b0;
      grant_idx  = '0;
      launch_vec = '0;
      sum        = '0;
      cand       = '0;
      for (int k = 0; k < NUM_ENGINES; k++) begin
         sum = {1'b0, rr_ptr} + (RR_W+1)'(k);
         if (sum >= (RR_W+1)'(NUM_ENGINES)) sum = sum - (RR_W+1)'(NUM_ENGINES);
         cand = sum[RR_W-1:0];
         if (!launch && eligible[cand]) begin
            launch    = 1'b1;
            grant_idx = cand;
         end
      end
      if (launch) launch_vec[grant_idx] = 1'b1;
   end

   // FIFO storage carries no reset; only pointers and count qualify it.
   always_ff @(posedge clk) begin
      if (push_ok) begin
         pt_mem[wr_ptr]  <= plaintext_din;
         key_mem[wr_ptr] <= key_din;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr            <= '0;
         rd_ptr            <= '0;
         count             <= '0;
         rr_ptr            <= '0;
         overflow_dout     <= 1'b0;
         start_strobe_dout <= '0;
         plaintext_dout    <= '0;
         key_dout          <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
         if (launch)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push_ok, launch})
            2'b10:   count <= count + (PTR_W+1)'(1);
            2'b01:   count <= count - (PTR_W+1)'(1);
            default: count <= count;
         endcase
         if (drop) overflow_dout <= 1'b1;
         if (launch) begin
            rr_ptr <= (grant_idx == RR_W'(NUM_ENGINES-1)) ? '0 : grant_idx + RR_W'(1);
         end
         start_strobe_dout <= launch_vec;
         plaintext_dout    <= launch ? pt_mem[rd_ptr]  : '0;
         key_dout          <= launch ? key_mem[rd_ptr] : '0;
      end
   end

`ifdef DES_DISPATCH_STATS_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         jobs_issued_dout  <= '0;
         jobs_dropped_dout <= '0;
      end else begin
         if (launch) jobs_issued_dout <= jobs_issued_dout + 32'd1;
         if (drop && (jobs_dropped_dout != 16'hFFFF))
            jobs_dropped_dout <= jobs_dropped_dout + 16'd1;
      end
   end
`endif

endmodule
